// File: rtl/uart_frame_parser.sv
// Command frame parser for a UART byte stream: SOF, CMD, LEN, payload, CHK.
// Good frames are held with a valid/ack handshake; bad frames raise a one-cycle error pulse.
module uart_frame_parser #(
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  SOF     = 8'hA5,
  parameter int          TIMEOUT = 104167,
  localparam int         ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              ovr_err
);

  localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [7:0]        LEN_MAX  = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD
  } state_t;

  state_t           state;
  logic [7:0]       cmd_q;
  logic [7:0]       len_q;
  logic [7:0]       chk;
  logic [7:0]       idx;
  logic [TMO_W-1:0] tmo;
  logic [7:0]       pbuf [MAX_LEN];
  logic             buf_we;

  assign buf_we = rx_done && (state == S_DATA);

  // Payload storage is deliberately left unreset; only DATA writes it, so a held frame stays intact.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pbuf[idx[ADDR_W-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 8'd0;
    end else if ({1'b0, rd_addr} < DEPTH) begin
      rd_data <= pbuf[rd_addr];
    end else begin
      rd_data <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      chk         <= 8'd0;
      idx         <= 8'd0;
      tmo         <= '0;
      frame_valid <= 1'b0;
      frame_cmd   <= 8'd0;
      frame_len   <= 8'd0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      ovr_err     <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      ovr_err   <= 1'b0;

      // Inter-byte idle timer only runs while a frame is partially received.
      if (rx_done || state == S_IDLE || state == S_HOLD) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + TMO_W'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (rx_done && rx_data == SOF) begin
            state <= S_CMD;
          end
        end

        S_CMD, S_LEN, S_DATA, S_CHK: begin
          if (rx_done) begin
            unique case (state)
              S_CMD: begin
                cmd_q <= rx_data;
                chk   <= rx_data;
                state <= S_LEN;
              end
              S_LEN: begin
                len_q <= rx_data;
                chk   <= chk ^ rx_data;
                idx   <= 8'd0;
                if (rx_data > LEN_MAX) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LEN;
                  state     <= S_IDLE;
                end else if (rx_data == 8'd0) begin
                  state <= S_CHK;
                end else begin
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                chk <= chk ^ rx_data;
                idx <= idx + 8'd1;
                if (idx == len_q - 8'd1) begin
                  state <= S_CHK;
                end
              end
              default: begin
                if (rx_data == chk) begin
                  frame_valid <= 1'b1;
                  frame_cmd   <= cmd_q;
                  frame_len   <= len_q;
                  state       <= S_HOLD;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CHK;
                  state     <= S_IDLE;
                end
              end
            endcase
          end else if (tmo == TMO_LAST) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_IDLE;
          end
        end

        S_HOLD: begin
          // A byte arriving while a frame is held is lost, even on the release cycle.
          if (rx_done) begin
            ovr_err <= 1'b1;
          end
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: a frame-level byte model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 20;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         ADDR_W  = 4;

  logic              clk;
  logic              rst;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              frame_valid;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              ovr_err;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .SOF    (SOF),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .frame_valid(frame_valid),
    .frame_cmd  (frame_cmd),
    .frame_len  (frame_len),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .ovr_err    (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: the bytes of the frame in progress are collected in a queue and
  // judged by their position (CMD, LEN, payload, CHK) once each arrives.
  bit         m_in_frame;
  bit         m_holding;
  logic [7:0] m_bytes [$];
  int         m_idle;
  int         m_n;
  logic [7:0] m_x;
  logic [7:0] m_mem [MAX_LEN];
  bit         m_known [MAX_LEN];
  logic       exp_valid, exp_err, exp_ovr;
  logic [7:0] exp_cmd, exp_len, exp_rd;
  logic [1:0] exp_code;
  bit         exp_rd_known;

  initial begin
    for (int i = 0; i < MAX_LEN; i++) m_known[i] = 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_frame   = 0;
      m_holding    = 0;
      m_idle       = 0;
      m_bytes.delete();
      exp_valid    = 0;
      exp_cmd      = 8'd0;
      exp_len      = 8'd0;
      exp_err      = 0;
      exp_code     = 2'd0;
      exp_ovr      = 0;
      exp_rd       = 8'd0;
      exp_rd_known = 1;
    end else begin
      exp_err      = 0;
      exp_code     = 2'd0;
      exp_ovr      = 0;
      exp_rd_known = m_known[rd_addr];
      exp_rd       = m_mem[rd_addr];
      if (m_holding) begin
        if (rx_done) exp_ovr = 1;
        if (frame_ack) begin
          m_holding = 0;
          exp_valid = 0;
        end
      end else if (!m_in_frame) begin
        if (rx_done && rx_data == SOF) begin
          m_in_frame = 1;
          m_idle     = 0;
          m_bytes.delete();
        end
      end else if (rx_done) begin
        m_idle = 0;
        m_bytes.push_back(rx_data);
        m_n = m_bytes.size();
        if (m_n == 2 && int'(m_bytes[1]) > MAX_LEN) begin
          exp_err    = 1;
          exp_code   = 2'd2;
          m_in_frame = 0;
        end else if (m_n >= 3 && m_n <= int'(m_bytes[1]) + 2) begin
          m_mem[m_n-3]   = rx_data;
          m_known[m_n-3] = 1;
        end else if (m_n >= 3 && m_n == int'(m_bytes[1]) + 3) begin
          m_x = 8'd0;
          for (int i = 0; i < m_n - 1; i++) m_x = m_x ^ m_bytes[i];
          m_in_frame = 0;
          if (m_x == rx_data) begin
            m_holding = 1;
            exp_valid = 1;
            exp_cmd   = m_bytes[0];
            exp_len   = m_bytes[1];
          end else begin
            exp_err  = 1;
            exp_code = 2'd1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          exp_err    = 1;
          exp_code   = 2'd3;
          m_in_frame = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("frame_valid", {31'd0, frame_valid}, {31'd0, exp_valid});
      checkOutput("frame_cmd", {24'd0, frame_cmd}, {24'd0, exp_cmd});
      checkOutput("frame_len", {24'd0, frame_len}, {24'd0, exp_len});
      checkOutput("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
      checkOutput("err_code", {30'd0, err_code}, {30'd0, exp_code});
      checkOutput("ovr_err", {31'd0, ovr_err}, {31'd0, exp_ovr});
      if (exp_rd_known) checkOutput("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom_range(0, 255));
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendGoodFrame();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h30, 0);
  endtask

  task automatic readByte(input logic [ADDR_W-1:0] addr, input logic [7:0] exp, input string name);
    @(negedge clk);
    rd_addr = addr;
    @(negedge clk);
    checkOutput(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic ackFrame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checkOutput("valid after ack", {31'd0, frame_valid}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, {31'd0, frame_valid}, 32'd0);
    checkOutput({tag, " cmd"}, {24'd0, frame_cmd}, 32'd0);
    checkOutput({tag, " len"}, {24'd0, frame_len}, 32'd0);
    checkOutput({tag, " rd_data"}, {24'd0, rd_data}, 32'd0);
    checkOutput({tag, " err"}, {31'd0, frame_err}, 32'd0);
    checkOutput({tag, " code"}, {30'd0, err_code}, 32'd0);
    checkOutput({tag, " ovr"}, {31'd0, ovr_err}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    frame_ack = 1'b0;
    rd_addr   = '0;
    #7 rst = 1'b1;
    #1 armed = 1;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] good frame");
    sendGoodFrame();
    checkOutput("good valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("good cmd", {24'd0, frame_cmd}, 32'h01);
    checkOutput("good len", {24'd0, frame_len}, 32'h02);
    readByte(4'd0, 8'h11, "good payload0");
    readByte(4'd1, 8'h22, "good payload1");
    ackFrame();

    $display("[TB] junk and zero length");
    applyStimulus(8'h3C, 0);
    checkOutput("junk no err", {31'd0, frame_err}, 32'd0);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h07, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h07, 0);
    checkOutput("zlen valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("zlen cmd", {24'd0, frame_cmd}, 32'h07);
    checkOutput("zlen len", {24'd0, frame_len}, 32'h00);
    ackFrame();

    $display("[TB] bad checksum and length");
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h31, 0);
    checkOutput("badchk err", {31'd0, frame_err}, 32'd1);
    checkOutput("badchk code", {30'd0, err_code}, 32'd1);
    checkOutput("badchk valid", {31'd0, frame_valid}, 32'd0);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h20, 0);
    checkOutput("badlen err", {31'd0, frame_err}, 32'd1);
    checkOutput("badlen code", {30'd0, err_code}, 32'd2);
    applyStimulus(8'h10, 2);

    $display("[TB] timeout");
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("tmo early", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    checkOutput("tmo err", {31'd0, frame_err}, 32'd1);
    checkOutput("tmo code", {30'd0, err_code}, 32'd3);
    sendGoodFrame();
    checkOutput("post-tmo valid", {31'd0, frame_valid}, 32'd1);
    ackFrame();
    // A byte landing exactly on the terminal idle cycle keeps the frame alive.
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, TIMEOUT - 2);
    applyStimulus(8'h02, 0);
    checkOutput("edge no err", {31'd0, frame_err}, 32'd0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h30, 0);
    checkOutput("edge valid", {31'd0, frame_valid}, 32'd1);
    ackFrame();

    $display("[TB] hold overrun");
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h09, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h5A, 0);
    applyStimulus(8'h52, 0);
    checkOutput("hold valid", {31'd0, frame_valid}, 32'd1);
    applyStimulus(8'h55, 0);
    checkOutput("ovr pulse", {31'd0, ovr_err}, 32'd1);
    checkOutput("ovr cmd kept", {24'd0, frame_cmd}, 32'h09);
    readByte(4'd0, 8'h5A, "ovr payload");
    @(negedge clk);
    frame_ack = 1'b1;
    rx_done   = 1'b1;
    rx_data   = 8'hA5;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_done   = 1'b0;
    checkOutput("ack+rx ovr", {31'd0, ovr_err}, 32'd1);
    checkOutput("ack+rx valid", {31'd0, frame_valid}, 32'd0);
    sendGoodFrame();
    checkOutput("after ack+rx valid", {31'd0, frame_valid}, 32'd1);

    $display("[TB] reset while held and mid-frame");
    rd_addr = 4'd1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("rst hold");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h11, 0);
    #2 rst = 1'b1;
    #1 checkAllZero("rst frame");
    @(negedge clk);
    rst = 1'b0;
    sendGoodFrame();
    checkOutput("post-rst valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("post-rst cmd", {24'd0, frame_cmd}, 32'h01);
    ackFrame();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Downstream consumer of the UART receiver's byte stream (rx_done pulse + rx_data). Assembles bytes into command frames: SOF 0xA5, CMD, LEN, LEN payload bytes, CHK. Checks each frame and buffers its payload. Presents each good frame to the control logic with a valid/ack handshake.

Parameters:
MAX_LEN, 16, maximum payload bytes; buffer depth (1..255)
SOF, 8'hA5, start-of-frame byte
TIMEOUT, 104167, idle clk cycles between bytes inside a frame before abort (about 2 byte times at 50 MHz/9600)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_done  input  1  one-cycle pulse: rx_data holds a new received byte
rx_data  input  8  received byte, valid when rx_done=1
frame_valid  output  1  level; good frame held for consumer
frame_cmd  output  8  CMD byte of held frame
frame_len  output  8  LEN of held frame
frame_ack  input  1  consumer releases held frame; sampled only while frame_valid=1
rd_addr  input  clog2(MAX_LEN)  payload buffer read address
rd_data  output  8  payload byte at rd_addr; registered, 1-cycle latency
frame_err  output  1  one-cycle pulse on aborted frame
err_code  output  2  cause, valid while frame_err=1: 1=checksum, 2=length, 3=timeout
ovr_err  output  1  one-cycle pulse: byte dropped while a frame is held

Behaviour:
- Reset values: frame_valid=0, frame_cmd=0, frame_len=0, rd_data=0, frame_err=0, err_code=0, ovr_err=0, FSM=IDLE, counters=0. Buffer contents are not reset.
- Bytes are consumed only on cycles where rx_done=1. rx_data is ignored otherwise.
- Running checksum = XOR of CMD, LEN and all payload bytes. The frame is good when the CHK byte equals this value.
- FSM states:
  - IDLE: byte==SOF -> CMD. Any other byte is discarded silently, with no error.
  - CMD: store CMD, chk=CMD -> LEN.
  - LEN: LEN>MAX_LEN -> frame_err, err_code=2, -> IDLE. LEN==0 -> CHK. Otherwise idx=0 -> DATA. In all cases chk^=LEN.
  - DATA: buf[idx]=byte, chk^=byte, idx++. When idx reaches LEN-1 on a write -> CHK.
  - CHK: match -> frame_valid=1 on the next cycle, -> HOLD. Mismatch -> frame_err, err_code=1, -> IDLE.
  - HOLD: frame_ack=1 -> frame_valid=0 on the next cycle, -> IDLE. Any rx_done in HOLD is dropped and pulses ovr_err the next cycle.
- Latency: frame_valid rises 1 cycle after the rx_done carrying a correct CHK. frame_err and ovr_err follow the offending rx_done by 1 cycle.
- frame_cmd and frame_len are updated only when the frame is accepted. They are stable for the whole time frame_valid=1.
- Timeout counter:
  - Runs in CMD, LEN, DATA and CHK; clears on every rx_done.
  - Reaching TIMEOUT-1 -> frame_err, err_code=3, -> IDLE.
  - Inactive in IDLE and HOLD.
- Simultaneous events:
  - rx_done and timeout terminal count in the same cycle: the byte wins and the counter clears.
  - frame_ack and rx_done in the same HOLD cycle: release to IDLE, the byte is dropped and ovr_err pulses. Consequence: a SOF arriving on the ack cycle is lost.
- A SOF byte inside CMD/LEN/DATA/CHK is treated as data; the parser does not resynchronise.
- The buffer is written only in DATA, so a held frame's payload is never overwritten. rd_data beyond frame_len is stale but defined.
- Asserting rst mid-frame or in HOLD returns to IDLE and clears all outputs immediately (asynchronous).

Test Plan:
- Good frame: bytes A5 01 02 11 22 30 -> frame_valid=1 1 cycle after last rx_done, frame_cmd=01, frame_len=02; rd_addr 0/1 gives rd_data 11/22 one cycle later; pulse frame_ack -> frame_valid=0 next cycle.
- Zero length and junk: bytes 3C A5 07 00 07 -> 3C ignored with no error; frame_valid with frame_cmd=07, frame_len=00.
- Bad checksum and length: A5 01 02 11 22 31 -> frame_err with err_code=1, no frame_valid. A5 01 20 (MAX_LEN=16) -> frame_err with err_code=2 one cycle after the LEN byte.
- Timeout: A5 01 then no rx_done for TIMEOUT cycles -> frame_err with err_code=3. A following good frame A5 01 02 11 22 30 is accepted normally.
- Hold overrun: while frame_valid=1, send byte 55 -> ovr_err pulse; frame_cmd and payload unchanged. rx_done coincident with frame_ack -> ovr_err, frame_valid=0, state IDLE.
- Reset: assert rst after A5 01 02 11 -> all outputs 0 immediately. After release, A5 01 02 11 22 30 is accepted.
